// File: rtl/calc_sched_pkg.sv
// Shared types and encodings for the calc request scheduler.
package calc_sched_pkg;

   localparam int unsigned NUM_PORTS = 4;
   localparam int unsigned IDX_W     = 2;
   localparam int unsigned CMD_W     = 4;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned RESP_W    = 2;
   localparam int unsigned CNT_W     = 8;

   localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
   localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
   localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

   localparam logic [RESP_W-1:0] RESP_NONE     = 2'd0;
   localparam logic [RESP_W-1:0] RESP_OK       = 2'd1;
   localparam logic [RESP_W-1:0] RESP_ERR      = 2'd2;
   localparam logic [RESP_W-1:0] RESP_INTERNAL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } sched_state_t;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
   } calc_req_t;

   function automatic logic cmd_is_valid(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last granted port.
module calc_rr_arbiter
   import calc_sched_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last,
   output logic [NUM_PORTS-1:0] grant_c
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      grant_c = '0;
      idx     = '0;
      for (int i = 1; i <= int'(NUM_PORTS); i++) begin
         idx = last + IDX_W'(i);
         if ((grant_c == '0) && req[idx]) begin
            grant_c[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/calc_req_scheduler.sv
// Four-port calc request capture, round-robin ALU issue, timeout and response steering.
// Optional build macro CALC_CMD_FILTER_EN answers invalid commands locally with RESP_ERR.
module calc_req_scheduler
   import calc_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [CMD_W-1:0]  req1_cmd_in,
   input  logic [CMD_W-1:0]  req2_cmd_in,
   input  logic [CMD_W-1:0]  req3_cmd_in,
   input  logic [CMD_W-1:0]  req4_cmd_in,
   input  logic [DATA_W-1:0] req1_data_in,
   input  logic [DATA_W-1:0] req2_data_in,
   input  logic [DATA_W-1:0] req3_data_in,
   input  logic [DATA_W-1:0] req4_data_in,
   output logic [RESP_W-1:0] out_resp1,
   output logic [RESP_W-1:0] out_resp2,
   output logic [RESP_W-1:0] out_resp3,
   output logic [RESP_W-1:0] out_resp4,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic [DATA_W-1:0] out_data4,
   output logic              alu_valid,
   output logic [CMD_W-1:0]  alu_cmd,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   input  logic              alu_done,
   input  logic [RESP_W-1:0] alu_resp,
   input  logic [DATA_W-1:0] alu_data,
   output logic              error_found
);

   logic [CMD_W-1:0]     cmd_in  [NUM_PORTS];
   logic [DATA_W-1:0]    data_in [NUM_PORTS];
   calc_req_t            req_q   [NUM_PORTS];
   logic [RESP_W-1:0]    resp_q  [NUM_PORTS];
   logic [DATA_W-1:0]    rdata_q [NUM_PORTS];
   logic [NUM_PORTS-1:0] cap_q, pend_q;
   logic [NUM_PORTS-1:0] accept_c, violate_c, grant_c;
   logic [IDX_W-1:0]     grant_idx_c, gnt_q, last_q;
   logic [CNT_W-1:0]     wait_cnt_q;
   logic                 filtered_c;
   sched_state_t         state_q;

   assign cmd_in[0]  = req1_cmd_in;
   assign cmd_in[1]  = req2_cmd_in;
   assign cmd_in[2]  = req3_cmd_in;
   assign cmd_in[3]  = req4_cmd_in;
   assign data_in[0] = req1_data_in;
   assign data_in[1] = req2_data_in;
   assign data_in[2] = req3_data_in;
   assign data_in[3] = req4_data_in;

   assign out_resp1 = resp_q[0];
   assign out_resp2 = resp_q[1];
   assign out_resp3 = resp_q[2];
   assign out_resp4 = resp_q[3];
   assign out_data1 = rdata_q[0];
   assign out_data2 = rdata_q[1];
   assign out_data3 = rdata_q[2];
   assign out_data4 = rdata_q[3];

   calc_rr_arbiter u_arb (
      .req     (pend_q),
      .last    (last_q),
      .grant_c (grant_c)
   );

   // A port may take a new command in its own RESP cycle; the operand2 cycle ignores cmd.
   always_comb begin
      accept_c    = '0;
      violate_c   = '0;
      grant_idx_c = '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         if ((cmd_in[p] != CMD_NOP) && !cap_q[p]) begin
            if (!pend_q[p] || ((state_q == ST_RESP) && (gnt_q == IDX_W'(p)))) begin
               accept_c[p] = 1'b1;
            end else begin
               violate_c[p] = 1'b1;
            end
         end
         if (grant_c[p]) begin
            grant_idx_c = IDX_W'(p);
         end
      end
   end

   always_comb begin
`ifdef CALC_CMD_FILTER_EN
      filtered_c = !cmd_is_valid(req_q[grant_idx_c].cmd);
`else
      filtered_c = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_q  <= '0;
         pend_q <= '0;
         for (int p = 0; p < int'(NUM_PORTS); p++) begin
            req_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (accept_c[p]) begin
               cap_q[p]     <= 1'b1;
               req_q[p].cmd <= cmd_in[p];
               req_q[p].op1 <= data_in[p];
            end else if (cap_q[p]) begin
               cap_q[p]     <= 1'b0;
               req_q[p].op2 <= data_in[p];
            end
            if (cap_q[p]) begin
               pend_q[p] <= 1'b1;
            end else if ((state_q == ST_RESP) && (gnt_q == IDX_W'(p))) begin
               pend_q[p] <= 1'b0;
            end
         end
      end
   end

   // Scheduler FSM; response buses default to zero and are loaded only on entry to RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         last_q      <= IDX_W'(NUM_PORTS - 1);
         wait_cnt_q  <= '0;
         alu_valid   <= 1'b0;
         alu_cmd     <= '0;
         alu_op1     <= '0;
         alu_op2     <= '0;
         error_found <= 1'b0;
         for (int p = 0; p < int'(NUM_PORTS); p++) begin
            resp_q[p]  <= RESP_NONE;
            rdata_q[p] <= '0;
         end
      end else begin
         alu_valid   <= 1'b0;
         error_found <= |violate_c;
         for (int p = 0; p < int'(NUM_PORTS); p++) begin
            resp_q[p]  <= RESP_NONE;
            rdata_q[p] <= '0;
         end
         case (state_q)
            ST_IDLE: begin
               if (|pend_q) begin
                  gnt_q  <= grant_idx_c;
                  last_q <= grant_idx_c;
                  if (filtered_c) begin
                     resp_q[grant_idx_c] <= RESP_ERR;
                     state_q             <= ST_RESP;
                  end else begin
                     alu_valid <= 1'b1;
                     alu_cmd   <= req_q[grant_idx_c].cmd;
                     alu_op1   <= req_q[grant_idx_c].op1;
                     alu_op2   <= req_q[grant_idx_c].op2;
                     state_q   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               wait_cnt_q <= '0;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (alu_done) begin
                  resp_q[gnt_q]  <= alu_resp;
                  rdata_q[gnt_q] <= alu_data;
                  state_q        <= ST_RESP;
               end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  resp_q[gnt_q] <= RESP_INTERNAL;
                  state_q       <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
